// File: rtl/coefficient_scheduler_if.sv
// Symbol, coefficient and block-handoff signals of the coefficient scheduler.
// The scheduler connects through the slave modport; the environment uses master.
interface coefficient_scheduler_if;
  logic              sym_valid;
  logic              sym_ready;
  logic        [3:0] sym_run;
  logic signed [7:0] sym_value;
  logic              coef_valid;
  logic        [3:0] coef_run;
  logic signed [7:0] coef_value;
  logic              tbl_valid;
  logic              blk_ready;
  logic        [1:0] comp_id;
  logic              mcu_done;
  logic              err;

  modport master (
    output sym_valid, sym_run, sym_value, tbl_valid, blk_ready,
    input  sym_ready, coef_valid, coef_run, coef_value, comp_id, mcu_done, err
  );

  modport slave (
    input  sym_valid, sym_run, sym_value, tbl_valid, blk_ready,
    output sym_ready, coef_valid, coef_run, coef_value, comp_id, mcu_done, err
  );
endinterface

// File: rtl/coefficient_scheduler.sv
// Buffers (run, value) symbols, issues them to the table generator while tracking
// the zig-zag position, and sequences blocks Y..Y, Cb, Cr through the MCU.
module coefficient_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int Y_BLOCKS   = 4
) (
  input logic                    clk,
  input logic                    rst,
  coefficient_scheduler_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int RUN_W  = 4;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW     = 3;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] CB_BLK    = BW'(Y_BLOCKS);
  localparam logic [BW-1:0] LAST_BLK  = BW'(Y_BLOCKS + 1);

  typedef enum logic [1:0] {
    ISSUE      = 2'd0,
    WAIT_TABLE = 2'd1,
    WAIT_SINK  = 2'd2
  } state_t;

  logic [RUN_W+DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [AW:0]             fill;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [RUN_W-1:0]        head_run;
  logic signed [DATA_W-1:0] head_value;

  state_t                  state_q;
  state_t                  state_d;
  logic [6:0]              pos_q;
  logic [6:0]              pos_d;
  logic [7:0]              pos_sum;
  logic [BW-1:0]           blk_idx;
  logic                    issue;
  logic                    end_blk;
  logic                    ovf;
  logic                    adv;
  logic [1:0]              comp_id;

  logic                    vld_p1;
  logic                    mcu_p1;
  logic                    err_q;
  logic [RUN_W-1:0]        coef_run_p1;
  logic signed [DATA_W-1:0] coef_value_p1;

  function automatic logic [7:0] pos_advance(input logic [6:0] pos,
                                             input logic [RUN_W-1:0] run);
    return {1'b0, pos} + 8'(run) + 8'd1;
  endfunction

  // An overflowing run is clipped so the coefficient lands on position 63.
  function automatic logic [RUN_W-1:0] sat_run(input logic [6:0]       pos,
                                               input logic [RUN_W-1:0] run,
                                               input logic             clip);
    return clip ? RUN_W'(7'd63 - pos) : run;
  endfunction

  assign fill       = wr_ptr - rd_ptr;
  assign full       = (fill == DEPTH_CNT);
  assign empty      = (wr_ptr == rd_ptr);
  assign push       = bus.sym_valid && !full;
  assign head_run   = mem[rd_ptr[AW-1:0]][RUN_W+DATA_W-1:DATA_W];
  assign head_value = $signed(mem[rd_ptr[AW-1:0]][DATA_W-1:0]);
  assign pos_sum    = pos_advance(pos_q, head_run);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {bus.sym_run, bus.sym_value};
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    pop     = 1'b0;
    issue   = 1'b0;
    end_blk = 1'b0;
    ovf     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      ISSUE: begin
        if (!empty) begin
          pop     = 1'b1;
          issue   = 1'b1;
          ovf     = (pos_sum > 8'd64);
          // (0,0) at position 0 is a zero DC difference, not end-of-block.
          end_blk = (pos_sum >= 8'd64) ||
                    ((pos_q != 7'd0) && (head_run == '0) && (head_value == '0));
          if (end_blk) begin
            state_d = WAIT_TABLE;
            pos_d   = 7'd0;
          end else begin
            pos_d = pos_sum[6:0];
          end
        end
      end
      WAIT_TABLE: begin
        if (bus.tbl_valid) begin
          state_d = WAIT_SINK;
        end
      end
      WAIT_SINK: begin
        if (bus.blk_ready) begin
          adv     = 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ISSUE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pos_q   <= 7'd0;
      blk_idx <= '0;
      err_q   <= 1'b0;
      mcu_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (issue && ovf) begin
        err_q <= 1'b1;
      end
      if (adv) begin
        blk_idx <= (blk_idx == LAST_BLK) ? '0 : blk_idx + 1'b1;
      end
      mcu_p1 <= adv && (blk_idx == LAST_BLK);
    end
  end

  // Issue stage: popped symbol registered toward the table generator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1        <= 1'b0;
      coef_run_p1   <= '0;
      coef_value_p1 <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) begin
        coef_run_p1   <= sat_run(pos_q, head_run, ovf);
        coef_value_p1 <= head_value;
      end
    end
  end

  always_comb begin
    comp_id = 2'd0;
    if (blk_idx == CB_BLK) begin
      comp_id = 2'd1;
    end else if (blk_idx > CB_BLK) begin
      comp_id = 2'd2;
    end
  end

  assign bus.sym_ready  = !full;
  assign bus.coef_valid = vld_p1;
  assign bus.coef_run   = coef_run_p1;
  assign bus.coef_value = coef_value_p1;
  assign bus.comp_id    = comp_id;
  assign bus.mcu_done   = mcu_p1;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_coefficient_scheduler.sv
// Directed bench for coefficient_scheduler: a position/block model predicts every
// coefficient strobe, plus literal expectations for the key scenarios.
module tb_coefficient_scheduler;
  localparam int FIFO_DEPTH = 4;
  localparam int Y_BLOCKS   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coefficient_scheduler_if bus ();

  coefficient_scheduler #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .Y_BLOCKS  (Y_BLOCKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int  run;
    int  value;
    int  comp;
    bit  ends;
    bit  err;
  } exp_t;

  exp_t exp_q[$];
  int   m_pos;
  int   m_blk;
  bit   m_err;

  int checks;
  int errors;
  int n_strobe;
  int mcu_seen;
  int log_run [1024];
  int log_val [1024];
  bit auto_tbl;
  int tbl_req_cnt;
  int tbl_ack_cnt;
  int base;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Spec-level model: position arithmetic per symbol in arrival order.
  task automatic model_push(input int run, input int value);
    exp_t e;
    int   nxt;
    nxt     = m_pos + run + 1;
    e.value = value;
    e.comp  = (m_blk < Y_BLOCKS) ? 0 : ((m_blk == Y_BLOCKS) ? 1 : 2);
    e.ends  = (nxt >= 64) || (m_pos != 0 && run == 0 && value == 0);
    if (nxt > 64) begin
      e.run = 63 - m_pos;
      m_err = 1'b1;
    end else begin
      e.run = run;
    end
    e.err = m_err;
    if (e.ends) begin
      m_pos = 0;
      m_blk = (m_blk + 1) % (Y_BLOCKS + 2);
    end else begin
      m_pos = nxt;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pos = 0;
    m_blk = 0;
    m_err = 1'b0;
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send_sym(input int run, input int value);
    bus.sym_valid = 1'b1;
    bus.sym_run   = 4'(run);
    bus.sym_value = 8'(value);
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.sym_ready) begin
        model_push(run, value);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("sym_accept_timeout", 0, 1);
  endtask

  task automatic idle();
    bus.sym_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk(name, exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sym_ready"},  int'(bus.sym_ready),  1);
    chk({tag, "_coef_valid"}, int'(bus.coef_valid), 0);
    chk({tag, "_coef_run"},   int'(bus.coef_run),   0);
    chk({tag, "_coef_value"}, int'(bus.coef_value), 0);
    chk({tag, "_comp_id"},    int'(bus.comp_id),    0);
    chk({tag, "_mcu_done"},   int'(bus.mcu_done),   0);
    chk({tag, "_err"},        int'(bus.err),        0);
  endtask

  // Compare process: every strobe is checked against the model; also drives tbl_valid.
  initial begin : compare
    exp_t e;
    bit   tbl_next;
    tbl_next      = 1'b0;
    bus.tbl_valid = 1'b0;
    forever begin
      @(negedge clk);
      bus.tbl_valid = tbl_next || (tbl_req_cnt != tbl_ack_cnt);
      tbl_ack_cnt   = tbl_req_cnt;
      tbl_next      = 1'b0;
      if (bus.mcu_done === 1'b1) mcu_seen++;
      if (bus.coef_valid === 1'b1) begin
        if (n_strobe < 1024) begin
          log_run[n_strobe] = int'(bus.coef_run);
          log_val[n_strobe] = int'(bus.coef_value);
        end
        n_strobe++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("coef_run",   int'(bus.coef_run),   e.run);
          chk("coef_value", int'(bus.coef_value), e.value);
          chk("comp_id",    int'(bus.comp_id),    e.comp);
          chk("err",        int'(bus.err),        int'(e.err));
          if (e.ends) tbl_next = auto_tbl;
        end
      end
    end
  end

  initial begin : main
    checks = 0; errors = 0; n_strobe = 0; mcu_seen = 0;
    tbl_req_cnt = 0; tbl_ack_cnt = 0; auto_tbl = 1'b0;
    model_reset();
    rst           = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_run   = 4'd0;
    bus.sym_value = 8'sd0;
    bus.blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic block: (0,5),(0,3),(2,-1),(0,0); hold in WAIT_TABLE until tbl_valid.
    send_sym(0, 5); send_sym(0, 3); send_sym(2, -1); send_sym(0, 0);
    idle();
    repeat (6) @(negedge clk);
    chk("basic_strobes", n_strobe, 4);
    chk("basic_run0", log_run[0], 0); chk("basic_val0", log_val[0], 5);
    chk("basic_run1", log_run[1], 0); chk("basic_val1", log_val[1], 3);
    chk("basic_run2", log_run[2], 2); chk("basic_val2", log_val[2], -1);
    chk("basic_run3", log_run[3], 0); chk("basic_val3", log_val[3], 0);
    send_sym(0, 9);
    idle();
    repeat (6) @(negedge clk);
    chk("hold_in_wait_table", n_strobe, 4);
    tbl_req_cnt++;
    wait_drain("drain_after_tbl");
    chk("issue_after_handoff", n_strobe, 5);
    auto_tbl = 1'b1;
    send_sym(0, 0);
    idle();
    wait_drain("drain_block1");

    // Full block of 64 run-0 coefficients ends without EOB.
    for (int i = 0; i < 64; i++) send_sym(0, i + 1);
    idle();
    wait_drain("drain_full_block");
    chk("full_block_last_run", log_run[n_strobe-1], 0);
    chk("full_block_last_val", log_val[n_strobe-1], 64);
    chk("full_block_err", int'(bus.err), 0);

    // Overflow: reach pos 60 then (5,7).
    send_sym(0, 1); send_sym(15, 1); send_sym(15, 1); send_sym(15, 1);
    send_sym(10, 1); send_sym(5, 7);
    idle();
    wait_drain("drain_overflow");
    chk("overflow_run", log_run[n_strobe-1], 3);
    chk("overflow_val", log_val[n_strobe-1], 7);
    chk("overflow_err", int'(bus.err), 1);

    // Cb and Cr blocks close the MCU.
    send_sym(0, 2); send_sym(0, 0); send_sym(0, -3); send_sym(0, 0);
    idle();
    wait_drain("drain_chroma");
    chk("mcu_done_once", mcu_seen, 1);
    chk("comp_after_mcu", int'(bus.comp_id), 0);

    // Back-pressure while the sink is not ready.
    bus.blk_ready = 1'b0;
    base = n_strobe;
    send_sym(0, 4); send_sym(0, 0);
    send_sym(0, 1); send_sym(0, 2); send_sym(0, 3); send_sym(0, 4);
    bus.sym_valid = 1'b1;
    bus.sym_run   = 4'd0;
    bus.sym_value = 8'sd5;
    repeat (6) @(negedge clk);
    #1;
    chk("fifo_full_ready", int'(bus.sym_ready), 0);
    chk("no_issue_in_wait_sink", n_strobe, base + 2);
    bus.blk_ready = 1'b1;
    send_sym(0, 5); send_sym(0, 6); send_sym(0, 0);
    idle();
    wait_drain("drain_backpressure");
    chk("backpressure_strobes", n_strobe, base + 9);

    // Asynchronous reset during ISSUE with three symbols still queued.
    bus.blk_ready = 1'b0;
    send_sym(0, 7); send_sym(0, 0);
    send_sym(0, 1); send_sym(0, 2); send_sym(0, 3); send_sym(0, 4);
    idle();
    repeat (6) @(negedge clk);
    base = n_strobe;
    bus.blk_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (n_strobe >= base + 1) break;
    end
    chk("strobe_before_reset", n_strobe, base + 1);
    chk("err_before_reset", int'(bus.err), 1);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_sym(0, 0); send_sym(0, 6); send_sym(0, 0);
    idle();
    wait_drain("drain_after_reset");
    chk("after_reset_strobes", n_strobe, base + 4);
    chk("dc_zero_run",  log_run[n_strobe-3], 0);
    chk("dc_zero_val",  log_val[n_strobe-3], 0);
    chk("after_dc_val", log_val[n_strobe-2], 6);
    chk("err_after_reset", int'(bus.err), 0);
    chk("mcu_total", mcu_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/coefficient_scheduler.md
COEFFICIENT_SCHEDULER -- requirements
Module: coefficient_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4; symbol FIFO entries, power of two, 2..16.
REQ-002 Parameter Y_BLOCKS, default 4; luma blocks per MCU, 1..4.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 sym_valid  in  1  upstream (Huffman side) symbol present.
REQ-006 sym_ready  out  1  scheduler accepts symbol this cycle.
REQ-007 sym_run  in  4  zero-run length preceding coefficient.
REQ-008 sym_value  in  8  signed coefficient, two's complement.
REQ-009 coef_valid  out  1  one-cycle strobe to table generator (is_new_coefficient).
REQ-010 coef_run  out  4  run passed to table generator.
REQ-011 coef_value  out  8  coefficient passed to table generator.
REQ-012 tbl_valid  in  1  table generator pulse: 64-entry table complete.
REQ-013 blk_ready  in  1  downstream block consumer accepts completed table.
REQ-014 comp_id  out  2  component of current block: 0=Y, 1=Cb, 2=Cr.
REQ-015 mcu_done  out  1  one-cycle pulse when last block of MCU is handed off.
REQ-016 err  out  1  sticky run-overflow flag.

Function
REQ-017 Symbol FIFO: push when sym_valid && sym_ready; sym_ready = FIFO not full, independent of FSM state; no bypass when empty.
REQ-018 FSM states: ISSUE, WAIT_TABLE, WAIT_SINK; reset state ISSUE.
REQ-019 ISSUE: when FIFO non-empty, pop one entry per cycle; coef_valid, coef_run, coef_value are registered and valid the cycle after the pop.
REQ-020 Latency: symbol accepted at edge N appears on coef_* after edge N+1 (at earliest).
REQ-021 Position counter pos (7 bits, 0..63) mirrors the generator: on each issue pos <= pos+run+1, or 0 at end of block.
REQ-022 End of block: pos+run+1 == 64, or (pos != 0 && run == 0 && value == 0) (EOB); after issuing it go WAIT_TABLE, pos <= 0, no further pops.
REQ-023 Overflow: pos+run+1 > 64 -> issue with coef_run = 63-pos, value unchanged, set err, treat as end of block.
REQ-024 At pos == 0 a (run 0, value 0) symbol is a DC difference of 0, not EOB.
REQ-025 WAIT_TABLE: wait for tbl_valid, then WAIT_SINK; tbl_valid in any other state ignored.
REQ-026 WAIT_SINK: when blk_ready high, advance block index and return to ISSUE next cycle; blk_ready may be sampled the same cycle tbl_valid is seen only in WAIT_SINK.
REQ-027 Block index 0..Y_BLOCKS+1: comp_id = 0 for index < Y_BLOCKS, 1 for Y_BLOCKS, 2 for Y_BLOCKS+1; comp_id changes only on advance.
REQ-028 On advance from index Y_BLOCKS+1: mcu_done pulses one cycle, index wraps to 0.
REQ-029 Simultaneous push and pop allowed in any non-full state; FIFO count unchanged.
REQ-030 coef_valid never high in WAIT_TABLE or WAIT_SINK except the single strobe of the end-of-block symbol.

Reset
REQ-031 rst low asynchronously clears FIFO (empty), pos=0, block index=0, state ISSUE.
REQ-032 Reset outputs: sym_ready=1 after release, coef_valid=0, coef_run=0, coef_value=0, comp_id=0, mcu_done=0, err=0.
REQ-033 Reset mid-block discards buffered symbols; first symbol after release is treated as DC (pos 0).
REQ-034 err clears only by reset.

Verification
REQ-035 Symbols (0,5),(0,3),(2,-1),(0,0) back-to-back -> four coef_valid strobes; pos 0->1->2->5->0; WAIT_TABLE entered after fourth.
REQ-036 63 symbols run 0 after DC (64 total) -> end at pos 63+0+1=64, no EOB needed; err=0.
REQ-037 pos=60, symbol (5,7) -> coef_run=3, err=1, WAIT_TABLE.
REQ-038 Six blocks with blk_ready held high, tbl_valid one cycle after each end -> comp_id 0,0,0,0,1,2; mcu_done pulses once after sixth; comp_id back to 0.
REQ-039 sym_valid held high, blk_ready low during WAIT_SINK -> FIFO fills to 4, sym_ready=0, no coef_valid; raise blk_ready -> issue resumes, no symbol lost or duplicated.
REQ-040 rst low during ISSUE with 3 symbols queued -> all outputs at reset values asynchronously; after release next symbol issued as DC.
